hermes_port_arbiter: RTL and testbench
======================================

// Module: hermes_port_arbiter
// PURPOSE
//  Packet-level round-robin arbiter sharing one Hermes boundary port of the many-core between N_SRC
//  peripheral sources (e.g. MA injector, App injector, future I/O). Sits between the peripheral
//  outputs and the rx/credit/data inputs of a boundary PE port, replacing one-peripheral-per-port
//  wiring. Holds a grant for a whole packet (header, size, payload) so packets never interleave.
// PARAMETERS
//  N_SRC       2     number of requesting sources (>=2)
//  FLIT_SIZE   32    flit width in bits; the size flit counts payload flits
//  WDT_CYCLES  1024  stall cycles before watchdog error (only with HERMES_ARB_WATCHDOG_EN)
// PORTS
//  clk_i         in   1                  clock
//  rst_i         in   1                  reset, asynchronous, active-high
//  src_rx_i      in   [N_SRC]            source flit valid
//  src_credit_o  out  [N_SRC]            credit back to source (downstream credit, granted source only)
//  src_data_i    in   [N_SRC][FLIT_SIZE] source flit
//  src_en_i      in   [N_SRC]            source eligible (e.g. PE release_peripheral); checked at arbitration only
//  noc_tx_o      out  1                  flit valid to PE port
//  noc_credit_i  in   1                  PE port can accept a flit
//  noc_data_o    out  FLIT_SIZE          flit to PE port
//  grant_o       out  [N_SRC]            one-hot current owner, 0 when idle
//  busy_o        out  1                  packet in progress (state != IDLE)
//  wdt_error_o   out  1                  sticky stall error (0 when feature compiled out)
// BEHAVIOUR
//  - Transfer: flit moves in a cycle when noc_tx_o && noc_credit_i.
//  - Datapath combinational: in non-IDLE, noc_tx_o=src_rx_i[g], noc_data_o=src_data_i[g],
//    src_credit_o[g]=noc_credit_i, all other src_credit_o=0. In IDLE: noc_tx_o=0, noc_data_o=0,
//    src_credit_o=0, so no flit passes during arbitration.
//  - FSM IDLE->HEADER->SIZE->(PAYLOAD)->IDLE:
//    IDLE: req = src_rx_i & src_en_i. If req!=0, grant first requester after last_grant (circular
//      search, last_grant+1 .. last_grant, wrap at N_SRC-1->0), register g, last_grant<=g, ->HEADER.
//      Arbitration latency 1 cycle: header transfers no earlier than the cycle after request.
//    HEADER: on transfer ->SIZE.
//    SIZE: on transfer load cnt<=src_data_i[g] (FLIT_SIZE-bit unsigned); value 0 ->IDLE, else ->PAYLOAD.
//    PAYLOAD: on transfer cnt<=cnt-1; transfer with cnt==1 ->IDLE.
//  - Back-to-back: the IDLE cycle between packets is mandatory (one bubble), even for the same source.
//  - src_en_i falling mid-packet: ignored; packet completes. src_rx_i low mid-packet: wait, grant held.
//  - Simultaneous requests: round-robin order only; no source served twice while another waits.
//  - Reset (any time, incl. mid-packet): state=IDLE, grant_o=0, busy_o=0, cnt=0,
//    last_grant=N_SRC-1 (source 0 has first priority), wdt_error_o=0; all outputs per IDLE rule.
//    Partial packet is abandoned; sources must be reset together with the arbiter.
// CONFIGURATION
//  HERMES_ARB_WATCHDOG_EN defined: stall counter (width $clog2(WDT_CYCLES+1)) increments each
//    non-IDLE cycle without transfer, clears on transfer or in IDLE; reaching WDT_CYCLES sets
//    wdt_error_o, sticky until reset; arbitration/datapath unaffected (grant not revoked).
//  Not defined: no counter logic; wdt_error_o tied 0.
// TESTING
//  1 Reset: rst_i=1 mid-packet for 3 cycles -> all outputs 0, next request from src1 only granted,
//    after src0 and src1 request together src0 wins first.
//  2 Single packet src0: hdr 0x0102, size 3, payload A,B,C, credit always 1 -> noc sees 5 flits in
//    consecutive cycles starting 1 cycle after src_rx_i; busy_o falls after C; grant_o=01 throughout.
//  3 Contention: src0 and src1 each hold 2 packets of size 2 -> order src0,src1,src0,src1, one idle
//    bubble between packets, no flit interleaving.
//  4 Backpressure: noc_credit_i toggled 1,0,0,1,... during payload -> src_credit_o[g] mirrors it,
//    no flit dropped/duplicated; size 0 packet -> 2 flits then IDLE.
//  5 Eligibility: src1 requests with src_en_i[1]=0 -> never granted; src_en_i[1] dropped after header
//    of granted packet -> packet finishes normally.
//  6 Watchdog (macro on, WDT_CYCLES=16): credit held 0 after header for 16 cycles -> wdt_error_o=1
//    on 16th stall cycle, stays 1 after traffic resumes; macro off -> wdt_error_o stays 0.

Source files
------------

// File: rtl/hermes_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hermes_port_arbiter
//  Purpose  : Packet-level round-robin arbiter that lets N_SRC peripheral
//             sources share one Hermes boundary port. A grant is held for a
//             whole packet (header, size, payload) so packets never
//             interleave. One mandatory idle cycle separates packets.
//  Option   : HERMES_ARB_WATCHDOG_EN - adds a stall watchdog that raises a
//             sticky wdt_error_o after WDT_CYCLES cycles without a transfer
//             while a packet is in progress. Undefined: wdt_error_o is 0.
//  Revision : 1.0 - initial release
// ============================================================================
module hermes_port_arbiter #(
  parameter int N_SRC      = 2,
  parameter int FLIT_SIZE  = 32,
  parameter int WDT_CYCLES = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_SRC-1:0]             src_rx_i,
  output logic [N_SRC-1:0]             src_credit_o,
  input  logic [N_SRC*FLIT_SIZE-1:0]   src_data_i,
  input  logic [N_SRC-1:0]             src_en_i,
  output logic                         noc_tx_o,
  input  logic                         noc_credit_i,
  output logic [FLIT_SIZE-1:0]         noc_data_o,
  output logic [N_SRC-1:0]             grant_o,
  output logic                         busy_o,
  output logic                         wdt_error_o
);

  // Source index width; at least one bit even for tiny configurations.
  localparam int c_IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [c_IDX_W-1:0]   c_LAST_SRC = c_IDX_W'(N_SRC - 1);
  localparam logic [FLIT_SIZE-1:0] c_CNT_ONE  = {{(FLIT_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_SIZE    = 2'd2,
    S_PAYLOAD = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_IDX_W-1:0]   r_grant;
  logic [c_IDX_W-1:0]   w_grant_nxt;
  logic [c_IDX_W-1:0]   r_last_grant;
  logic [c_IDX_W-1:0]   w_last_grant_nxt;
  logic [FLIT_SIZE-1:0] r_cnt;
  logic [FLIT_SIZE-1:0] w_cnt_nxt;

  logic [N_SRC-1:0]     w_req;
  logic                 w_found;
  logic [c_IDX_W-1:0]   w_pick;
  logic [N_SRC-1:0]     w_grant_oh;
  logic                 w_busy;
  logic                 w_sel_rx;
  logic [FLIT_SIZE-1:0] w_sel_data;
  logic                 w_xfer;

  // Round-robin search: first eligible requester after the last grant.
  always_comb begin
    w_req   = src_rx_i & src_en_i;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      if (!w_found && w_req[(int'(r_last_grant) + k) % N_SRC]) begin
        w_found = 1'b1;
        w_pick  = c_IDX_W'((int'(r_last_grant) + k) % N_SRC);
      end
    end
  end

  // Select the owner's flit and build the one-hot owner vector.
  always_comb begin
    w_grant_oh          = '0;
    w_grant_oh[r_grant] = 1'b1;
    w_sel_rx            = src_rx_i[r_grant];
    w_sel_data          = src_data_i[int'(r_grant)*FLIT_SIZE +: FLIT_SIZE];
  end

  assign w_busy = (r_state != S_IDLE);
  assign w_xfer = noc_tx_o & noc_credit_i;

  // Datapath is gated in IDLE so nothing leaks through while arbitrating.
  always_comb begin
    noc_tx_o     = w_busy & w_sel_rx;
    noc_data_o   = w_busy ? w_sel_data : '0;
    grant_o      = w_busy ? w_grant_oh : '0;
    src_credit_o = (w_busy & noc_credit_i) ? w_grant_oh : '0;
    busy_o       = w_busy;
  end

  // Packet framing: header, size (loads payload count), payload countdown.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_cnt_nxt        = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt      = S_HEADER;
          w_grant_nxt      = w_pick;
          w_last_grant_nxt = w_pick;
        end
      end
      S_HEADER: begin
        if (w_xfer) begin
          w_state_nxt = S_SIZE;
        end
      end
      S_SIZE: begin
        if (w_xfer) begin
          w_cnt_nxt   = w_sel_data;
          w_state_nxt = (w_sel_data == '0) ? S_IDLE : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (w_xfer) begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
          if (r_cnt == c_CNT_ONE) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, owner and counter registers; reset gives source 0 first priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= c_LAST_SRC;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

`ifdef HERMES_ARB_WATCHDOG_EN
  localparam int c_WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [c_WDT_W-1:0] c_WDT_MAX = c_WDT_W'(WDT_CYCLES);

  logic               w_stall;
  logic [c_WDT_W-1:0] w_stall_nxt;
  logic [c_WDT_W-1:0] r_stall_cnt;
  logic               r_wdt_err;

  // Count consecutive non-IDLE cycles without a transfer; saturate at limit.
  always_comb begin
    w_stall     = w_busy & ~w_xfer;
    w_stall_nxt = r_stall_cnt;
    if (!w_stall) begin
      w_stall_nxt = '0;
    end else if (r_stall_cnt != c_WDT_MAX) begin
      w_stall_nxt = r_stall_cnt + 1'b1;
    end
  end

  // Stall counter and sticky error flag; only reset clears the flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_wdt_err   <= 1'b0;
    end else begin
      r_stall_cnt <= w_stall_nxt;
      if (w_stall_nxt == c_WDT_MAX) begin
        r_wdt_err <= 1'b1;
      end
    end
  end

  assign wdt_error_o = r_wdt_err;
`else
  // No watchdog in this build: the comparison is constant false, so the
  // output is tied low while WDT_CYCLES stays a referenced parameter.
  assign wdt_error_o = (WDT_CYCLES < 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_hermes_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hermes_port_arbiter
//  Purpose  : Self-checking bench for hermes_port_arbiter (N_SRC=2,
//             FLIT_SIZE=32, WDT_CYCLES=16). Source models stream queued
//             packets; expected flits go to a scoreboard queue in the order
//             the arbiter must deliver them and are compared on transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hermes_port_arbiter;

  localparam int N  = 2;
  localparam int FW = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [N-1:0]  src_rx_i;
  logic [N-1:0]  src_credit_o;
  logic [N*FW-1:0] src_data_i;
  logic [N-1:0]  src_en_i;
  logic          noc_tx_o;
  logic          noc_credit_i;
  logic [FW-1:0] noc_data_o;
  logic [N-1:0]  grant_o;
  logic          busy_o;
  logic          wdt_error_o;

  hermes_port_arbiter #(.N_SRC(N), .FLIT_SIZE(FW), .WDT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .src_rx_i(src_rx_i), .src_credit_o(src_credit_o),
    .src_data_i(src_data_i), .src_en_i(src_en_i), .noc_tx_o(noc_tx_o),
    .noc_credit_i(noc_credit_i), .noc_data_o(noc_data_o), .grant_o(grant_o),
    .busy_o(busy_o), .wdt_error_o(wdt_error_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  src;
    logic        hdr;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] sq0[$];
  logic [31:0] sq1[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_xfer = 0;
  int          hdr_cyc = 0;
  int          last_cyc = 0;
  bit          chk_idle = 1'b0;
  logic [N-1:0] acc = '0;
  exp_t        e;
  logic [1:0]  eg;
  logic [1:0]  ec;

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // Queue one packet at a source; optionally expect it on the NoC side.
  task automatic push_pkt(input int s, input logic [31:0] hdr, input int size,
                          input logic [31:0] base, input bit to_exp);
    logic [31:0] fl;
    exp_t        x;
    for (int i = 0; i < size + 2; i++) begin
      fl = (i == 0) ? hdr : (i == 1) ? 32'(size) : base + 32'(i - 2);
      if (s == 0) sq0.push_back(fl); else sq1.push_back(fl);
      if (to_exp) begin
        x.data = fl; x.src = 8'(s); x.hdr = (i == 0); x.last = (i == size + 1);
        exp_q.push_back(x);
      end
    end
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exp_q.size() == 0 && !chk_idle) begin ok = 1'b1; break; end
    end
    if (!ok) begin exp_q.delete(); sq0.delete(); sq1.delete(); chk_idle = 1'b0; end
  endtask

  task automatic wait_xfers(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (n_xfer >= target) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    tick();
  endtask

  // Source models: pop a flit when the previous cycle accepted it.
  initial forever begin
    @(posedge clk);
    #1;
    if (acc[0] && sq0.size() > 0) void'(sq0.pop_front());
    if (acc[1] && sq1.size() > 0) void'(sq1.pop_front());
    src_rx_i[0] = (sq0.size() > 0);
    src_rx_i[1] = (sq1.size() > 0);
    src_data_i  = {(sq1.size() > 0) ? sq1[0] : 32'h0, (sq0.size() > 0) ? sq0[0] : 32'h0};
  end

  // Monitor: scoreboard pops, credit mirroring and inter-packet bubble.
  initial forever begin
    @(negedge clk);
    cyc++;
    acc = src_credit_o & src_rx_i;
    if (!rst_i) begin
      if (chk_idle) begin
        n_cmp++;
        if (busy_o !== 1'b0 || grant_o !== 2'b00 || noc_tx_o !== 1'b0) begin
          n_err++;
          $display("FAIL bubble: busy=%b grant=%b tx=%b, required 0/00/0", busy_o, grant_o, noc_tx_o);
        end
        chk_idle = 1'b0;
      end
      if (busy_o) begin
        ec = noc_credit_i ? grant_o : 2'b00;
        n_cmp++;
        if (src_credit_o !== ec) begin
          n_err++;
          $display("FAIL credit_mirror: src_credit=%b required %b", src_credit_o, ec);
        end
      end
      if (noc_tx_o && noc_credit_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_flit: data=%h grant=%b, none expected", noc_data_o, grant_o);
        end else begin
          e  = exp_q.pop_front();
          eg = 2'b01 << e.src;
          if (noc_data_o !== e.data || grant_o !== eg) begin
            n_err++;
            $display("FAIL flit: data=%h grant=%b, required data=%h grant=%b", noc_data_o, grant_o, e.data, eg);
          end
          n_xfer++;
          last_cyc = cyc;
          if (e.hdr) hdr_cyc = cyc;
          if (e.last) chk_idle = 1'b1;
        end
      end
    end
  end

  task automatic test_reset();
    bit ok;
    logic [FW+5:0] obs;
    tick(); tick(); tick();
    @(negedge clk); #1;
    obs = {noc_tx_o, busy_o, wdt_error_o, grant_o, src_credit_o[0], noc_data_o};
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL reset_initial: outputs=%h required 0", obs); end
    rst_i = 1'b0;
    tick();
    push_pkt(0, 32'h0A0A, 3, 32'h100, 1'b1);
    wait_xfers(n_xfer + 2, 20, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL reset_midpkt_start: xfers=%0d required >=2", n_xfer); end
    rst_i = 1'b1;
    @(negedge clk); #1;
    obs = {noc_tx_o, busy_o, wdt_error_o, grant_o, src_credit_o[1], noc_data_o};
    n_cmp++;
    if (obs !== '0 || src_credit_o !== 2'b00) begin
      n_err++; $display("FAIL reset_midpkt: outputs=%h credit=%b required 0", obs, src_credit_o);
    end
    tick();
    sq0.delete(); sq1.delete(); exp_q.delete(); chk_idle = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    tick();
    // Source 0 must win first after reset even though it was granted last.
    push_pkt(0, 32'h0B0B, 1, 32'h110, 1'b1);
    push_pkt(1, 32'h1B1B, 1, 32'h210, 1'b1);
    wait_drain(40, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL reset_priority: drained=%b required 1", ok); end
    push_pkt(1, 32'h1C1C, 1, 32'h220, 1'b1);
    wait_drain(30, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL reset_src1_alone: drained=%b required 1", ok); end
  endtask

  task automatic test_single();
    bit ok;
    int rx_cyc;
    rx_cyc = -100;
    push_pkt(0, 32'h0102, 3, 32'hA, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (src_rx_i[0]) begin rx_cyc = cyc; break; end
    end
    wait_drain(30, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL single_drain: drained=%b required 1", ok); end
    n_cmp++;
    if (hdr_cyc !== rx_cyc + 1) begin
      n_err++; $display("FAIL single_latency: header cycle=%0d required %0d", hdr_cyc, rx_cyc + 1);
    end
    n_cmp++;
    if (last_cyc !== rx_cyc + 5) begin
      n_err++; $display("FAIL single_consecutive: last cycle=%0d required %0d", last_cyc, rx_cyc + 5);
    end
  endtask

  task automatic test_contention();
    bit ok;
    apply_reset();
    push_pkt(0, 32'h0C01, 2, 32'h310, 1'b1);
    push_pkt(1, 32'h1C01, 2, 32'h410, 1'b1);
    push_pkt(0, 32'h0C02, 2, 32'h320, 1'b1);
    push_pkt(1, 32'h1C02, 2, 32'h420, 1'b1);
    wait_drain(80, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL contention_drain: drained=%b required 1", ok); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int start;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    start = n_xfer;
    ok = 1'b0;
    push_pkt(0, 32'h0D0D, 4, 32'h500, 1'b1);
    for (int i = 0; i < 80; i++) begin
      noc_credit_i = pat[i % 4];
      tick();
      if (exp_q.size() == 0 && !chk_idle) begin ok = 1'b1; break; end
    end
    noc_credit_i = 1'b1;
    n_cmp++;
    if (!ok || n_xfer - start !== 6) begin
      n_err++; $display("FAIL backpressure: drained=%b flits=%0d required 1/6", ok, n_xfer - start);
      exp_q.delete(); chk_idle = 1'b0;
    end
    start = n_xfer;
    push_pkt(1, 32'h1D1D, 0, 32'h0, 1'b1);
    wait_drain(20, ok);
    n_cmp++;
    if (!ok || n_xfer - start !== 2) begin
      n_err++; $display("FAIL size_zero: drained=%b flits=%0d required 1/2", ok, n_xfer - start);
    end
  endtask

  task automatic test_eligibility();
    bit ok;
    int bad;
    bad = 0;
    src_en_i = 2'b01;
    push_pkt(1, 32'h1E1E, 2, 32'h600, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk); #1;
      if (grant_o[1] || busy_o) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL disabled_src: granted cycles=%0d required 0", bad); end
    sq1.delete();
    tick(); tick();
    src_en_i = 2'b11;
    push_pkt(1, 32'h1F1F, 2, 32'h700, 1'b1);
    wait_xfers(n_xfer + 1, 20, ok);
    src_en_i = 2'b01;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL en_drop_header: header seen=%b required 1", ok); end
    wait_drain(30, ok);
    src_en_i = 2'b11;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL en_drop_finish: drained=%b required 1", ok); end
  endtask

  task automatic test_watchdog();
    bit   ok;
    logic want;
`ifdef HERMES_ARB_WATCHDOG_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    noc_credit_i = 1'b1;
    push_pkt(0, 32'h0E0E, 2, 32'h800, 1'b1);
    wait_xfers(n_xfer + 1, 20, ok);
    noc_credit_i = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    @(negedge clk); #1;
    n_cmp++;
    if (wdt_error_o !== 1'b0) begin n_err++; $display("FAIL wdt_15: wdt=%b required 0", wdt_error_o); end
    tick();
    @(negedge clk); #1;
    n_cmp++;
    if (wdt_error_o !== want) begin n_err++; $display("FAIL wdt_16: wdt=%b required %b", wdt_error_o, want); end
    tick();
    noc_credit_i = 1'b1;
    wait_drain(30, ok);
    n_cmp++;
    if (!ok || wdt_error_o !== want) begin
      n_err++; $display("FAIL wdt_sticky: drained=%b wdt=%b required 1/%b", ok, wdt_error_o, want);
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    src_rx_i     = '0;
    src_data_i   = '0;
    src_en_i     = 2'b11;
    noc_credit_i = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_eligibility();
    test_watchdog();
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
